// File: rtl/conv_psum_accumulator_pkg.sv
// Shared types and defaults for the convolution partial-sum accumulator.
package conv_psum_accumulator_pkg;

    localparam int DEF_PSUM_W  = 16;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_MAX_OUT = 32;
    localparam int IDX_W       = $clog2(DEF_MAX_OUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Oversized row widths are clamped to what the line buffer can hold.
    function automatic logic [4:0] clamp_size(input logic [4:0] sz, input logic [4:0] max_sz);
        return (sz > max_sz) ? max_sz : sz;
    endfunction

endpackage

// File: rtl/conv_psum_accumulator_if.sv
// Partial-sum input stream and accumulated-pixel output stream.
interface conv_psum_accumulator_if
    import conv_psum_accumulator_pkg::*;
#(
    parameter int PSUM_W = DEF_PSUM_W,
    parameter int ACC_W  = DEF_ACC_W
);
    logic              psum_valid;
    logic              psum_ready;
    logic [PSUM_W-1:0] psum_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [ACC_W-1:0]  out_data;

    modport master (
        output psum_valid, psum_data, out_ready,
        input  psum_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  psum_valid, psum_data, out_ready,
        output psum_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_psum_accumulator_psum_line_buf.sv
// One output row of accumulators: synchronous write, combinational read.
module psum_line_buf
    import conv_psum_accumulator_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUT,
    parameter int WIDTH = DEF_ACC_W,
    parameter int AW    = IDX_W
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/conv_psum_accumulator.sv
// Accumulates kernel_size rows of partial sums per output row, then drains the row.
// Build option: define CONV_PSUM_RELU_EN to clamp negative outputs to zero.
module conv_psum_accumulator
    import conv_psum_accumulator_pkg::*;
#(
    parameter int PSUM_W  = DEF_PSUM_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_i,
    input  logic [4:0]                    out_size_i,
    input  logic [2:0]                    kernel_size_i,
    conv_psum_accumulator_if.slave        bus,
    output logic                          frame_done_o
);
    localparam int         AW     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int         SZ_LIM = (MAX_OUT < 31) ? MAX_OUT : 31;
    localparam logic [4:0] SZ_MAX = 5'(SZ_LIM);

    state_e           state_q, state_d;
    logic [4:0]       size_q, size_d;
    logic [2:0]       ks_q, ks_d;
    logic [4:0]       col_q, col_d;
    logic [2:0]       kr_q, kr_d;
    logic [4:0]       idx_q, idx_d;
    logic [4:0]       row_q, row_d;
    logic             frame_q, frame_d;

    logic             accept;
    logic             hs;
    logic [4:0]       size_in;
    logic [AW-1:0]    raddr;
    logic [ACC_W-1:0] rdata;
    logic [ACC_W-1:0] wdata;
    logic [ACC_W-1:0] ext;

    assign size_in         = clamp_size(out_size_i, SZ_MAX);
    assign ext             = ACC_W'($signed(bus.psum_data));
    assign bus.psum_ready  = (state_q == ACCUM);
    assign bus.out_valid   = (state_q == DRAIN);
    // load has priority over both the psum and the output handshake
    assign accept          = bus.psum_valid && bus.psum_ready && !load_i;
    assign hs              = bus.out_valid && bus.out_ready && !load_i;

    assign raddr           = (state_q == DRAIN) ? AW'(idx_q) : AW'(col_q);
    assign wdata           = (kr_q == '0) ? ext : rdata + ext;

    psum_line_buf #(
        .DEPTH (MAX_OUT),
        .WIDTH (ACC_W),
        .AW    (AW)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (AW'(col_q)),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign bus.out_last = bus.out_valid && (idx_q == size_q - 5'd1);
`ifdef CONV_PSUM_RELU_EN
    assign bus.out_data = (bus.out_valid && !rdata[ACC_W-1]) ? rdata : '0;
`else
    assign bus.out_data = bus.out_valid ? rdata : '0;
`endif
    assign frame_done_o = frame_q;

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        ks_d    = ks_q;
        col_d   = col_q;
        kr_d    = kr_q;
        idx_d   = idx_q;
        row_d   = row_q;
        frame_d = 1'b0;

        if (load_i) begin
            size_d  = size_in;
            ks_d    = kernel_size_i;
            col_d   = '0;
            kr_d    = '0;
            idx_d   = '0;
            row_d   = '0;
            state_d = (size_in == '0 || kernel_size_i == '0) ? IDLE : ACCUM;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (col_q == size_q - 5'd1) begin
                            col_d = '0;
                            if (kr_q == ks_q - 3'd1) begin
                                kr_d    = '0;
                                state_d = DRAIN;
                            end else begin
                                kr_d = kr_q + 3'd1;
                            end
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (hs) begin
                        if (idx_q == size_q - 5'd1) begin
                            idx_d   = '0;
                            state_d = ACCUM;
                            if (row_q == size_q - 5'd1) begin
                                row_d   = '0;
                                frame_d = 1'b1;
                            end else begin
                                row_d = row_q + 5'd1;
                            end
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            size_q  <= '0;
            ks_q    <= '0;
            col_q   <= '0;
            kr_q    <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            ks_q    <= ks_d;
            col_q   <= col_d;
            kr_q    <= kr_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end
endmodule
